// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO sequencing block: drain FSM encoding
// and default data width.
package uart_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } drain_state_t;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin write arbiter: combinational grant into the FIFO,
// registered pointer naming the requester favoured next.
module uart_rr_arb2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              grant0,
    output logic              grant1,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data
);

    logic rr_ptr;
    logic pick0;
    logic pick1;
    logic live;

    // Grants are gated by rst_n so nothing reaches the FIFO while reset is held.
    always_comb begin
        pick0   = req0_valid & (~rr_ptr | ~req1_valid);
        pick1   = req1_valid & ( rr_ptr | ~req0_valid);
        live    = rst_n & ~hold;
        grant0  = live & pick0;
        grant1  = live & pick1;
        wr_en   = grant0 | grant1;
        wr_data = '0;
        if (grant0) begin
            wr_data = req0_data;
        end else if (grant1) begin
            wr_data = req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_fifo_arbiter.sv
// Sequences the UART byte FIFO: round-robin writes from two requesters and a
// drain FSM that pops one byte at a time and hands it to the TX engine.
module uart_fifo_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ack,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic [CNT_W-1:0]  tx_count
);

    drain_state_t state;
    logic [1:0]   lat_cnt;
    logic         can_pop;

    uart_rr_arb2 #(
        .DATA_W (DATA_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (fifo_full),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .grant0     (req0_ack),
        .grant1     (req1_ack),
        .wr_en      (fifo_wr_en),
        .wr_data    (fifo_din)
    );

    assign can_pop = en & ~fifo_empty;

    // fifo_rd_en is raised on entry to POP and dropped on exit, so it is high
    // for exactly the one POP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            fifo_rd_en <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_pop) begin
                        state      <= ST_POP;
                        fifo_rd_en <= 1'b1;
                    end
                end
                ST_POP: begin
                    fifo_rd_en <= 1'b0;
                    lat_cnt    <= 2'(RD_LAT - 1);
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        tx_data  <= fifo_dout;
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_count <= tx_count + CNT_W'(1);
                        if (can_pop) begin
                            state      <= ST_POP;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_arbiter.sv
// Scoreboard bench for uart_fifo_arbiter: two instances (RD_LAT 1 and 3) share
// stimulus, each with its own FIFO model and monitors.
module tb_uart_fifo_arbiter;

    typedef struct packed {
        logic       who;
        logic [7:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] cnt;
    } tx_exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        tx_ready;
    logic        full_force;
    logic        req0_valid;
    logic        req1_valid;
    logic [7:0]  req0_data;
    logic [7:0]  req1_data;

    logic [1:0]  req0_ack;
    logic [1:0]  req1_ack;
    logic [1:0]  fifo_wr_en;
    logic [1:0]  fifo_rd_en;
    logic [1:0]  fifo_full;
    logic [1:0]  fifo_empty;
    logic [1:0]  tx_valid;
    logic [7:0]  fifo_din  [2];
    logic [7:0]  fifo_dout [2];
    logic [7:0]  tx_data   [2];
    logic [15:0] tx_count  [2];

    wr_exp_t     wr_q [2][$];
    tx_exp_t     tx_q [2][$];
    int unsigned exp_period [2];
    int unsigned cyc;
    int          checks;
    int          errors;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d]: got 0x%0h, expected 0x%0h", name, g, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        logic [7:0] mem  [16];
        logic [7:0] pipe [3];
        logic [3:0] wp;
        logic [3:0] rp;
        logic [4:0] cnt;
        int unsigned last;
        bit          have_last;

        uart_fifo_arbiter #(
            .DATA_W (8),
            .RD_LAT (LAT),
            .CNT_W  (16)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .req0_valid (req0_valid),
            .req0_data  (req0_data),
            .req0_ack   (req0_ack[g]),
            .req1_valid (req1_valid),
            .req1_data  (req1_data),
            .req1_ack   (req1_ack[g]),
            .fifo_wr_en (fifo_wr_en[g]),
            .fifo_din   (fifo_din[g]),
            .fifo_full  (fifo_full[g]),
            .fifo_rd_en (fifo_rd_en[g]),
            .fifo_dout  (fifo_dout[g]),
            .fifo_empty (fifo_empty[g]),
            .tx_valid   (tx_valid[g]),
            .tx_data    (tx_data[g]),
            .tx_ready   (tx_ready),
            .tx_count   (tx_count[g])
        );

        // FIFO model: read data appears LAT cycles after the pop, poisoned otherwise.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp   <= '0;
                rp   <= '0;
                cnt  <= '0;
                for (int i = 0; i < 3; i++) pipe[i] <= 8'hEE;
            end else begin
                if (fifo_wr_en[g]) begin
                    mem[wp] <= fifo_din[g];
                    wp      <= wp + 4'd1;
                end
                if (fifo_rd_en[g]) rp <= rp + 4'd1;
                cnt     <= cnt + 5'(fifo_wr_en[g]) - 5'(fifo_rd_en[g]);
                pipe[0] <= fifo_rd_en[g] ? mem[rp] : 8'hEE;
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
        end

        assign fifo_dout[g]  = pipe[LAT-1];
        assign fifo_empty[g] = (cnt == 5'd0);
        assign fifo_full[g]  = full_force | (cnt == 5'd16);

        initial begin : mon
            wr_exp_t we;
            tx_exp_t te;
            have_last = 1'b0;
            last      = 0;
            forever begin
                @(negedge clk);
                if (exp_period[g] == 0) have_last = 1'b0;
                if (rst_n) begin
                    if (fifo_rd_en[g]) chk("rd_while_empty", g, 32'(fifo_empty[g]), 0);
                    if (fifo_wr_en[g] || req0_ack[g] || req1_ack[g]) begin
                        chk("wr_expected", g, 32'(wr_q[g].size() != 0), 1);
                        chk("wr_en_vs_ack", g, 32'(fifo_wr_en[g]), 32'(req0_ack[g] | req1_ack[g]));
                        if (wr_q[g].size() != 0) begin
                            we = wr_q[g].pop_front();
                            chk("wr_ack", g, {30'd0, req1_ack[g], req0_ack[g]}, we.who ? 32'd2 : 32'd1);
                            chk("wr_data", g, 32'(fifo_din[g]), 32'(we.data));
                        end
                    end
                    if (tx_valid[g] && tx_ready) begin
                        chk("tx_expected", g, 32'(tx_q[g].size() != 0), 1);
                        if (tx_q[g].size() != 0) begin
                            te = tx_q[g].pop_front();
                            chk("tx_data", g, 32'(tx_data[g]), 32'(te.data));
                            chk("tx_count", g, 32'(tx_count[g]), 32'(te.cnt));
                        end
                        if (exp_period[g] != 0 && have_last)
                            chk("tx_period", g, cyc - last, exp_period[g]);
                        last      = cyc;
                        have_last = (exp_period[g] != 0);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic who, input logic [7:0] d);
        wr_exp_t e;
        e.who  = who;
        e.data = d;
        for (int g = 0; g < 2; g++) wr_q[g].push_back(e);
    endtask

    task automatic push_tx(input logic [7:0] d, input logic [15:0] c);
        tx_exp_t e;
        e.data = d;
        e.cnt  = c;
        for (int g = 0; g < 2; g++) tx_q[g].push_back(e);
    endtask

    task automatic wait_both_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = tx_valid[0] & tx_valid[1];
        end
        chk(name, 0, 32'(ok), 1);
    endtask

    task automatic wait_rd(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = fifo_rd_en[0] & fifo_rd_en[1];
        end
        chk(name, 0, 32'(ok), 1);
    endtask

    task automatic wait_drained(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (tx_q[0].size() == 0) && (tx_q[1].size() == 0) &&
                 (wr_q[0].size() == 0) && (wr_q[1].size() == 0) && (tx_valid == 2'b00);
        end
        chk(name, 0, 32'(ok), 1);
    endtask

    task automatic write_req0(input logic [7:0] d);
        push_wr(1'b0, d);
        req0_valid = 1'b1;
        req0_data  = d;
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("wr_accept", g, 32'(req0_ack[g]), 1);
        step();
        req0_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0;
        int i1;
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        en = 1'b0;
        tx_ready = 1'b0;
        full_force = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data = '0;
        req1_data = '0;
        exp_period[0] = 0;
        exp_period[1] = 0;

        // Reset state, with a requester active to show writes are gated.
        repeat (2) @(posedge clk);
        req0_valid = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_tx_valid", g, 32'(tx_valid[g]), 0);
            chk("rst_rd_en", g, 32'(fifo_rd_en[g]), 0);
            chk("rst_wr_en", g, 32'(fifo_wr_en[g]), 0);
            chk("rst_tx_data", g, 32'(tx_data[g]), 0);
            chk("rst_tx_count", g, 32'(tx_count[g]), 0);
        end
        step();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Arbitration: both requesters continuously valid, grants alternate.
        push_wr(1'b0, 8'h10); push_wr(1'b1, 8'h20);
        push_wr(1'b0, 8'h11); push_wr(1'b1, 8'h21);
        push_wr(1'b0, 8'h12); push_wr(1'b1, 8'h22);
        i0 = 0;
        i1 = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req0_data = 8'h10 + 8'(i0);
            req1_data = 8'h20 + 8'(i1);
            @(negedge clk);
            if (req0_ack[0]) i0++;
            if (req1_ack[0]) i1++;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Full backpressure: held off while full, written the cycle full drops.
        full_force = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("full_no_wr", g, 32'(fifo_wr_en[g]), 0);
                chk("full_no_ack", g, 32'(req0_ack[g]), 0);
            end
            step();
        end
        push_wr(1'b0, 8'hA5);
        full_force = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("full_release_ack", g, 32'(req0_ack[g]), 1);
        step();
        req0_valid = 1'b0;

        // TX stall: SEND holds byte steady, no further pops.
        push_tx(8'h10, 16'd0);
        en = 1'b1;
        wait_both_valid("reach_send");
        for (int c = 0; c < 10; c++) begin
            for (int g = 0; g < 2; g++) begin
                chk("stall_valid", g, 32'(tx_valid[g]), 1);
                chk("stall_data", g, 32'(tx_data[g]), 32'h10);
                chk("stall_no_rd", g, 32'(fifo_rd_en[g]), 0);
            end
            @(negedge clk);
        end
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;

        // Async reset while the next byte sits in SEND.
        wait_both_valid("reach_send2");
        for (int g = 0; g < 2; g++) chk("pre_rst_count", g, 32'(tx_count[g]), 1);
        step();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req0_data = 8'h5A;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("midrst_tx_valid", g, 32'(tx_valid[g]), 0);
            chk("midrst_rd_en", g, 32'(fifo_rd_en[g]), 0);
            chk("midrst_wr_en", g, 32'(fifo_wr_en[g]), 0);
            chk("midrst_tx_count", g, 32'(tx_count[g]), 0);
        end
        step();
        req0_valid = 1'b0;
        en = 1'b0;
        rst_n = 1'b1;
        step();

        // Drain three bytes back to back with tx_ready tied high.
        write_req0(8'h11);
        write_req0(8'h22);
        write_req0(8'h33);
        push_tx(8'h11, 16'd0);
        push_tx(8'h22, 16'd1);
        push_tx(8'h33, 16'd2);
        exp_period[0] = 3;
        exp_period[1] = 5;
        tx_ready = 1'b1;
        en = 1'b1;
        wait_drained("drain3");
        exp_period[0] = 0;
        exp_period[1] = 0;
        for (int g = 0; g < 2; g++) chk("drain3_count", g, 32'(tx_count[g]), 3);
        step();

        // en dropped during WAIT: in-flight byte finishes, then FSM idles.
        en = 1'b0;
        write_req0(8'h41);
        write_req0(8'h42);
        write_req0(8'h43);
        write_req0(8'h44);
        push_tx(8'h41, 16'd3);
        en = 1'b1;
        wait_rd("first_pop");
        step();
        en = 1'b0;
        wait_drained("en_drop_byte");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("idle_no_rd", g, 32'(fifo_rd_en[g]), 0);
                chk("idle_no_valid", g, 32'(tx_valid[g]), 0);
            end
        end
        for (int g = 0; g < 2; g++) begin
            chk("idle_nonempty", g, 32'(fifo_empty[g]), 0);
            chk("en_drop_count", g, 32'(tx_count[g]), 4);
        end
        push_tx(8'h42, 16'd4);
        push_tx(8'h43, 16'd5);
        push_tx(8'h44, 16'd6);
        exp_period[0] = 3;
        exp_period[1] = 5;
        step();
        en = 1'b1;
        wait_drained("rerun");
        exp_period[0] = 0;
        exp_period[1] = 0;
        step();
        for (int g = 0; g < 2; g++) begin
            chk("final_count", g, 32'(tx_count[g]), 7);
            chk("final_empty", g, 32'(fifo_empty[g]), 1);
            chk("wr_q_left", g, 32'(wr_q[g].size()), 0);
            chk("tx_q_left", g, 32'(tx_q[g].size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
